// File: rtl/compositor_pkg.sv
// Shared definitions for the depth compositor block.
//   DEFAULT_COLOR_W / DEFAULT_DEPTH_W : default pixel and depth widths
//   BLANK_COLOR                       : colour driven outside the active region
//   bg_index()                        : winner code that denotes "background"
package compositor_pkg;

    localparam int DEFAULT_COLOR_W = 16;   // RGB565
    localparam int DEFAULT_DEPTH_W = 8;

    localparam logic [DEFAULT_COLOR_W-1:0] BLANK_COLOR = '0;

    // Background is encoded as one past the last layer index.
    function automatic int bg_index(input int num_layers);
        return num_layers;
    endfunction

endpackage

// File: rtl/layer_arbiter.sv
// Combinational depth arbiter: picks the nearest valid layer.
//   valid     : per-layer coverage bits
//   depth     : packed depths, layer i at [i*DEPTH_W +: DEPTH_W]; smaller = nearer
//   winner    : index of nearest valid layer, bg_index(NUM_LAYERS) if none
//   any_valid : at least one layer is valid
module layer_arbiter
    import compositor_pkg::*;
#(
    parameter  int NUM_LAYERS = 2,
    parameter  int DEPTH_W    = DEFAULT_DEPTH_W,
    localparam int WIN_W      = $clog2(NUM_LAYERS) + 1
) (
    input  logic [NUM_LAYERS-1:0]         valid,
    input  logic [NUM_LAYERS*DEPTH_W-1:0] depth,
    output logic [WIN_W-1:0]              winner,
    output logic                          any_valid
);

    logic [DEPTH_W-1:0] best_depth;

    // Linear min-scan; strict '<' keeps the lower index on equal depths.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        winner     = WIN_W'(bg_index(NUM_LAYERS));
        any_valid  = 1'b0;
        best_depth = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (valid[i] && (!any_valid || depth[i*DEPTH_W +: DEPTH_W] < best_depth)) begin
                winner     = WIN_W'(i);
                best_depth = depth[i*DEPTH_W +: DEPTH_W];
                any_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/depth_compositor.sv
// Two-stage pixel compositor: nearest valid layer by depth, background
// fallback, blanking outside the active region, and a per-frame count of
// player pixels hidden behind a nearer layer.
//   clk_in, rst_n_in            : pixel clock, async active-low reset
//   h_count_in, v_count_in      : position of the incoming pixel
//   pixel_in                    : background pixel
//   layer_valid_in/depth/color  : packed per-layer inputs
//   pixel_out, winner_out       : composited pixel and winning layer (2-cycle latency)
//   h_count_out, v_count_out    : positions aligned with pixel_out
//   occluded_count_out          : occluded-player count of the last completed frame
//   frame_done_out              : one-cycle pulse when occluded_count_out updates
module depth_compositor
    import compositor_pkg::*;
#(
    parameter  int ACTIVE_H_PIXELS = 1280,
    parameter  int ACTIVE_LINES    = 720,
    parameter  int NUM_LAYERS      = 2,
    parameter  int PLAYER_LAYER    = 0,
    parameter  int COLOR_W         = DEFAULT_COLOR_W,
    parameter  int DEPTH_W         = DEFAULT_DEPTH_W,
    parameter  int COUNT_W         = 20,
    localparam int WIN_W           = $clog2(NUM_LAYERS) + 1
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [10:0]                   h_count_in,
    input  logic [9:0]                    v_count_in,
    input  logic [COLOR_W-1:0]            pixel_in,
    input  logic [NUM_LAYERS-1:0]         layer_valid_in,
    input  logic [NUM_LAYERS*DEPTH_W-1:0] layer_depth_in,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color_in,
    output logic [COLOR_W-1:0]            pixel_out,
    output logic [10:0]                   h_count_out,
    output logic [9:0]                    v_count_out,
    output logic [WIN_W-1:0]              winner_out,
    output logic [COUNT_W-1:0]            occluded_count_out,
    output logic                          frame_done_out
);

    localparam logic [WIN_W-1:0]   BG_WINNER = WIN_W'(bg_index(NUM_LAYERS));
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    // ---------------- stage 0: combinational decisions ----------------
    logic [WIN_W-1:0]   arb_winner;
    logic               arb_any_valid;
    logic [COLOR_W-1:0] sel_color;
    logic               active;
    logic               player_hidden;
    logic               occluded;
    logic [DEPTH_W-1:0] player_depth;

    layer_arbiter #(
        .NUM_LAYERS (NUM_LAYERS),
        .DEPTH_W    (DEPTH_W)
    ) u_arbiter (
        .valid     (layer_valid_in),
        .depth     (layer_depth_in),
        .winner    (arb_winner),
        .any_valid (arb_any_valid)
    );

    always_comb begin
        sel_color = pixel_in;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (arb_any_valid && arb_winner == WIN_W'(i))
                sel_color = layer_color_in[i*COLOR_W +: COLOR_W];
        end
    end

    assign active       = (int'(h_count_in) < ACTIVE_H_PIXELS) && (int'(v_count_in) < ACTIVE_LINES);
    assign player_depth = layer_depth_in[PLAYER_LAYER*DEPTH_W +: DEPTH_W];

    // Only a strictly nearer layer hides the player; a tie leaves it visible.
    always_comb begin
        player_hidden = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (i != PLAYER_LAYER && layer_valid_in[i] &&
                layer_depth_in[i*DEPTH_W +: DEPTH_W] < player_depth)
                player_hidden = 1'b1;
        end
    end

    assign occluded = active && layer_valid_in[PLAYER_LAYER] && player_hidden;

    // ---------------- stage 1 registers ----------------
    logic [COLOR_W-1:0] s1_color;
    logic [WIN_W-1:0]   s1_winner;
    logic               s1_active;
    logic               s1_occ;
    logic [10:0]        s1_h;
    logic [9:0]         s1_v;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_color  <= '0;
            s1_winner <= '0;
            s1_active <= 1'b0;
            s1_occ    <= 1'b0;
            s1_h      <= '0;
            s1_v      <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
            s1_color  <= sel_color;
            s1_winner <= arb_winner;
            s1_active <= active;
            s1_occ    <= occluded;
            s1_h      <= h_count_in;
            s1_v      <= v_count_in;
        end
    end

    // ---------------- stage 2 registers: blanking ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pixel_out   <= '0;
            winner_out  <= '0;
            h_count_out <= '0;
            v_count_out <= '0;
        end else begin
            pixel_out   <= s1_active ? s1_color  : COLOR_W'(BLANK_COLOR);
            winner_out  <= s1_active ? s1_winner : BG_WINNER;
            h_count_out <= s1_h;
            v_count_out <= s1_v;
        end
    end

    // ---------------- occlusion counter ----------------
    // The count advances as pixels leave stage 1, so the report lands on the
    // same edge that puts the frame's last pixel onto pixel_out.
    logic [COUNT_W-1:0] occ_count;
    logic [COUNT_W-1:0] occ_count_next;
    logic               frame_end;

    assign frame_end      = (int'(s1_h) == ACTIVE_H_PIXELS - 1) && (int'(s1_v) == ACTIVE_LINES - 1);
    assign occ_count_next = (occ_count == COUNT_MAX) ? occ_count : occ_count + COUNT_W'(s1_occ);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            occ_count          <= '0;
            occluded_count_out <= '0;
            frame_done_out     <= 1'b0;
        end else if (frame_end) begin
            occ_count          <= '0;
            occluded_count_out <= occ_count_next;
            frame_done_out     <= 1'b1;
        end else begin
            occ_count          <= occ_count_next;
            frame_done_out     <= 1'b0;
        end
    end

endmodule

// File: doc/depth_compositor.md
# depth_compositor

Parametrised, pipelined pixel compositor for the HDMI video path: it sits between the per-layer pixel generators (wall, player, overlays) and the TMDS encoder. Each pixel, it selects the nearest valid layer by depth, falls back to the camera/background pixel, and blanks outside the active region. It also counts, per frame, player pixels hidden by a nearer layer (the wall collision metric) and reports that count once per frame to game logic.

## Interface
- ACTIVE_H_PIXELS, 1280, active pixels per line
- ACTIVE_LINES, 720, active lines per frame
- NUM_LAYERS, 2, number of depth layers (≥2)
- PLAYER_LAYER, 0, index of the player layer used for occlusion counting
- COLOR_W, 16, pixel width (RGB565)
- DEPTH_W, 8, depth width; smaller value = nearer
- COUNT_W, 20, occlusion counter width
- clk_in  input  1  pixel clock
- rst_n_in  input  1  asynchronous, active-low reset
- h_count_in  input  11  horizontal position of the current pixel
- v_count_in  input  10  vertical position of the current pixel
- pixel_in  input  COLOR_W  background pixel
- layer_valid_in  input  NUM_LAYERS  per-layer coverage; bit i set = layer i draws this pixel
- layer_depth_in  input  NUM_LAYERS*DEPTH_W  layer i at bits [i*DEPTH_W +: DEPTH_W]
- layer_color_in  input  NUM_LAYERS*COLOR_W  layer i at bits [i*COLOR_W +: COLOR_W]
- pixel_out  output  COLOR_W  composited pixel
- h_count_out  output  11  h_count_in delayed to align with pixel_out
- v_count_out  output  10  v_count_in delayed to align with pixel_out
- winner_out  output  $clog2(NUM_LAYERS)+1  winning layer index; value NUM_LAYERS = background
- occluded_count_out  output  COUNT_W  occluded-player-pixel count of the last completed frame
- frame_done_out  output  1  one-cycle pulse when occluded_count_out updates

## Operation
- Winner selection: among layers with the valid bit set, the lowest depth wins. Equal depths resolve to the lowest index. No valid layer selects the background.
- Active region: h_count_in < ACTIVE_H_PIXELS and v_count_in < ACTIVE_LINES. Outside it, pixel_out = BLANK_COLOR (0) and winner_out = NUM_LAYERS.
- Occlusion: a pixel is occluded when it is active, the PLAYER_LAYER bit is valid, and some other valid layer has depth strictly less than the player depth. Equal depth is not occluded.
- Counter: increments on each occluded pixel and saturates at 2^COUNT_W−1; it never wraps.
- Frame end: the pixel at (ACTIVE_H_PIXELS−1, ACTIVE_LINES−1) leaving stage 1.
  - On the next edge, occluded_count_out takes counter + that pixel's occlusion bit, saturated.
  - The counter clears to 0 on the same edge.
  - frame_done_out is high for that one cycle.
- Reset mid-frame: all state clears. The first report after reset covers a partial frame; game logic discards it.
- No back-pressure. One pixel is accepted every cycle.

## Timing
- Reset: every output and pipeline register is 0, including winner_out = 0 and frame_done_out = 0.
- Stage 1 (registered): comparison, winner index, selected colour, active flag, occlusion bit, and delayed counts.
- Stage 2 (registered): blanking mux onto pixel_out and winner_out; counts delayed a second time.
- Latency is exactly 2 cycles for pixel_out, winner_out, h_count_out and v_count_out.
- frame_done_out asserts in the same cycle that the final active pixel of the frame appears on pixel_out.
- occluded_count_out holds its value between frame_done_out pulses.

## Structure
- Shared package compositor_pkg holds:
  - COLOR_W and DEPTH_W defaults
  - BLANK_COLOR
  - the background-index function bg_index(NUM_LAYERS)
- Sub-module layer_arbiter: purely combinational, parametrised by NUM_LAYERS and DEPTH_W.
  - Inputs: valid and depth vectors.
  - Outputs: winner index and any_valid.
  - Implemented as a linear or tree min-scan with lowest-index priority.
  - Instantiated once, ahead of the stage-1 registers.

## Test plan
- Defaults. Layer 0 valid, depth 40, colour 16'hF800; layer 1 valid, depth 20, colour 16'h07E0; pixel at (10,10) → two cycles later pixel_out = 16'h07E0, winner_out = 1.
- Tie. Both layers valid at depth 30 → winner_out = 0, pixel_out = layer 0 colour, not counted as occluded.
- No layer valid, pixel_in = 16'h1234 → pixel_out = 16'h1234, winner_out = 2. At h=1280, v=5 → pixel_out = 0.
- Full 1280×720 frame with the wall (layer 1) nearer than the player on exactly 500 pixels, including the last active pixel.
  - frame_done_out pulses once, aligned with pixel (1279,719) on the output.
  - occluded_count_out = 500, unchanged until the next frame.
- COUNT_W = 4 with 20 occluded pixels → occluded_count_out = 15 (saturated).
- Assert rst_n_in low mid-line, asynchronously between edges → all outputs 0 immediately.
  - Release, then finish the frame with 7 occluded pixels → report = 7.
